senal_decoder: RTL and testbench

Alarm-signal decoder for the lab safety controller. Takes four raw sensor/button inputs (over-temperature, manual alarm, electrical overload, smoke), synchronizes and debounces them, then decodes them into three registered actuator commands:

- horn (`Bocina`)
- exhaust fan (`Extractor`)
- power cut (`Interrupcion`)

It sits between the asynchronous field inputs and the actuator drivers.

---
 rtl/senal_decoder.sv | 91 +++++++++
 tb/tb_senal_decoder.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/senal_decoder.sv
// Alarm decoder: sync + debounce four field inputs, decode to
// Bocina/Extractor (level) and Interrupcion (sticky until reset).
module senal_decoder #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic Temperatura,
  input  logic Manual,
  input  logic SobreCarga,
  input  logic Humo,
  output logic Bocina,
  output logic Extractor,
  output logic Interrupcion
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CLAST = CW'(DEBOUNCE_CYCLES - 1);

  // bit order: 0=T 1=M 2=S 3=H
  logic [3:0] raw;
  assign raw = {Humo, SobreCarga, Manual, Temperatura};

  logic [3:0]    sync_q [SYNC_STAGES];
  logic [3:0]    sync_d [SYNC_STAGES];
  logic [3:0]    filt_q, filt_d;
  logic [CW-1:0] cnt_q [4];
  logic [CW-1:0] cnt_d [4];
  logic          bocina_q, bocina_d;
  logic          extr_q, extr_d;
  logic          intr_q, intr_d;
  logic [3:0]    s;

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d[0] = raw;
    for (int i = 1; i < SYNC_STAGES; i++)
      sync_d[i] = sync_q[i-1];
  end

  // counter counts consecutive disagreeing edges; the edge that
  // would make it reach DEBOUNCE_CYCLES flips f instead
  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = '0;
      if (s[i] != filt_q[i]) begin
        if (cnt_q[i] == CLAST)
          filt_d[i] = s[i];
        else
          cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  always_comb begin
    bocina_d = filt_q[1] | filt_q[3] | filt_q[2];
    extr_d   = filt_q[0] | filt_q[3];
    intr_d   = intr_q | filt_q[2]
             | (filt_q[0] & filt_q[3]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        sync_q[i] <= '0;
      for (int i = 0; i < 4; i++)
        cnt_q[i] <= '0;
      filt_q   <= '0;
      bocina_q <= 1'b0;
      extr_q   <= 1'b0;
      intr_q   <= 1'b0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_d[i];
      for (int i = 0; i < 4; i++)
        cnt_q[i] <= cnt_d[i];
      filt_q   <= filt_d;
      bocina_q <= bocina_d;
      extr_q   <= extr_d;
      intr_q   <= intr_d;
    end
  end

  assign Bocina       = bocina_q;
  assign Extractor    = extr_q;
  assign Interrupcion = intr_q;

endmodule

// File: tb/tb_senal_decoder.sv
// Directed bench for senal_decoder (defaults: latency 7 edges).
// Outputs compared as {Bocina, Extractor, Interrupcion}.
module tb_senal_decoder;

  logic clk = 1'b0;
  logic reset;
  logic t, m, s, h;
  logic bo, ex, ir;

  int total = 0;
  int bad   = 0;

  senal_decoder dut (
    .clk         (clk),
    .reset       (reset),
    .Temperatura (t),
    .Manual      (m),
    .SobreCarga  (s),
    .Humo        (h),
    .Bocina      (bo),
    .Extractor   (ex),
    .Interrupcion(ir)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string    tag,
    input logic [2:0] got,
    input logic [2:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] outs();
    return {bo, ex, ir};
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    step(3);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    {t, m, s, h} = 4'b1111;
    step(3);
    chk("rst_hold", outs(), 3'b000);
    reset = 1'b0;
    step(6);
    chk("rst_e6", outs(), 3'b000);
    step(1);
    chk("rst_e7", outs(), 3'b111);

    {t, m, s, h} = 4'b0000;
    do_reset();
    chk("rst2", outs(), 3'b000);
    t = 1'b1;
    step(6);
    chk("t_e6", outs(), 3'b000);
    step(1);
    chk("t_e7", outs(), 3'b010);
    step(13);
    chk("t_hold", outs(), 3'b010);
    t = 1'b0;
    step(6);
    chk("t_fall_e6", outs(), 3'b010);
    step(1);
    chk("t_fall_e7", outs(), 3'b000);

    t = 1'b1;
    h = 1'b1;
    step(7);
    chk("fire", outs(), 3'b111);
    t = 1'b0;
    h = 1'b0;
    step(6);
    chk("fire_e6", outs(), 3'b111);
    step(1);
    chk("fire_e7", outs(), 3'b001);
    step(10);
    chk("latch", outs(), 3'b001);
    reset = 1'b1;
    step(1);
    chk("latch_clr", outs(), 3'b000);
    reset = 1'b0;

    m = 1'b1;
    step(7);
    chk("man", outs(), 3'b100);
    step(5);
    chk("man_hold", outs(), 3'b100);
    t = 1'b1;
    step(7);
    chk("man_t", outs(), 3'b110);
    m = 1'b0;
    t = 1'b0;
    step(7);
    chk("man_off", outs(), 3'b000);

    s = 1'b1;
    step(3);
    s = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      chk("glitch", outs(), 3'b000);
    end
    s = 1'b1;
    step(7);
    chk("ovl", outs(), 3'b101);
    step(3);
    s = 1'b0;
    step(6);
    chk("ovl_e6", outs(), 3'b101);
    step(1);
    chk("ovl_fall", outs(), 3'b001);
    do_reset();
    chk("ovl_rst", outs(), 3'b000);

    h = 1'b1;
    step(3);
    reset = 1'b1;
    step(3);
    chk("mid_rst", outs(), 3'b000);
    reset = 1'b0;
    step(6);
    chk("mid_e6", outs(), 3'b000);
    step(1);
    chk("mid_e7", outs(), 3'b110);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
